// File: rtl/centroid_tracker.sv
// Per-frame white-pixel centroid tracker with a 28-cycle restoring divider for each axis.
// Define MARKER_OVERLAY_EN to build the registered "+" marker overlay; otherwise marker is tied low.
module centroid_tracker #(
  parameter int MIN_PIXELS = 64,
  parameter int MARKER_LEN = 8
) (
  input  logic       ball_clock,
  input  logic       reset_n,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [9:0] h_value,
  input  logic [8:0] v_value,
  input  logic       seems_white,
  input  logic       freeze,
  output logic [9:0] vert_line,
  output logic [8:0] horz_line,
  output logic       ball_found,
  output logic       centroid_valid,
  output logic       marker
);

  localparam logic [2:0] ACCUM  = 3'd0;
  localparam logic [2:0] LATCH  = 3'd1;
  localparam logic [2:0] DIV_X  = 3'd2;
  localparam logic [2:0] DIV_Y  = 3'd3;
  localparam logic [2:0] UPDATE = 3'd4;

  localparam logic [18:0] MIN_COUNT = MIN_PIXELS[18:0];
  localparam logic [4:0]  DIV_LAST  = 5'd27;

  logic [2:0]  state;
  logic        v_sync_q;
  logic        frame_end;
  logic        pixel_hit;
  logic [27:0] sum_x;
  logic [27:0] sum_y;
  logic [18:0] count;
  logic [27:0] snap_sum_y;
  logic [18:0] snap_count;
  logic [27:0] div_quo;
  logic [18:0] div_rem;
  logic [4:0]  div_step;
  logic [9:0]  x_result;
  logic [8:0]  y_result;
  logic [19:0] trial;
  logic [19:0] trial_diff;
  logic        trial_ok;
  logic [18:0] rem_next;
  logic [27:0] quo_next;
  logic        detected;

  assign frame_end = v_sync_q & ~v_sync;
  assign pixel_hit = h_sync & v_sync & seems_white;
  assign detected  = (snap_count >= MIN_COUNT);

  // One restoring-divide step: the X snapshot sum is shifted through div_quo in place.
  always_comb begin
    trial      = {div_rem, div_quo[27]};
    trial_diff = trial - {1'b0, snap_count};
    trial_ok   = (trial >= {1'b0, snap_count});
    rem_next   = trial_ok ? trial_diff[18:0] : trial[18:0];
    quo_next   = {div_quo[26:0], trial_ok};
  end

  always_ff @(posedge ball_clock or negedge reset_n) begin
    if (!reset_n) begin
      v_sync_q <= 1'b0;
    end else begin
      v_sync_q <= v_sync;
    end
  end

  // A frame ending while the divider is busy is dropped by clearing its sums.
  always_ff @(posedge ball_clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_x <= '0;
      sum_y <= '0;
      count <= '0;
    end else if ((state == LATCH) || (frame_end && (state != ACCUM))) begin
      sum_x <= pixel_hit ? {18'd0, h_value} : 28'd0;
      sum_y <= pixel_hit ? {19'd0, v_value} : 28'd0;
      count <= pixel_hit ? 19'd1 : 19'd0;
    end else if (pixel_hit) begin
      sum_x <= sum_x + {18'd0, h_value};
      sum_y <= sum_y + {19'd0, v_value};
      count <= count + 19'd1;
    end
  end

  always_ff @(posedge ball_clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ACCUM;
      snap_sum_y <= '0;
      snap_count <= '0;
      div_quo    <= '0;
      div_rem    <= '0;
      div_step   <= '0;
      x_result   <= '0;
      y_result   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (frame_end) state <= LATCH;
        end
        LATCH: begin
          snap_sum_y <= sum_y;
          snap_count <= count;
          div_quo    <= sum_x;
          div_rem    <= '0;
          div_step   <= '0;
          state      <= (count < MIN_COUNT) ? UPDATE : DIV_X;
        end
        DIV_X: begin
          div_quo  <= quo_next;
          div_rem  <= rem_next;
          div_step <= div_step + 5'd1;
          if (div_step == DIV_LAST) begin
            x_result <= quo_next[9:0];
            div_quo  <= snap_sum_y;
            div_rem  <= '0;
            div_step <= '0;
            state    <= DIV_Y;
          end
        end
        DIV_Y: begin
          div_quo  <= quo_next;
          div_rem  <= rem_next;
          div_step <= div_step + 5'd1;
          if (div_step == DIV_LAST) begin
            y_result <= quo_next[8:0];
            state    <= UPDATE;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  always_ff @(posedge ball_clock or negedge reset_n) begin
    if (!reset_n) begin
      vert_line      <= '0;
      horz_line      <= '0;
      ball_found     <= 1'b0;
      centroid_valid <= 1'b0;
    end else begin
      centroid_valid <= 1'b0;
      if ((state == UPDATE) && !freeze) begin
        ball_found <= detected;
        if (detected) begin
          vert_line      <= x_result;
          horz_line      <= y_result;
          centroid_valid <= 1'b1;
        end
      end
    end
  end

`ifdef MARKER_OVERLAY_EN
  localparam logic [9:0] ARM = MARKER_LEN[9:0];

  logic [9:0] dx;
  logic [8:0] dy;
  logic       on_h_arm;
  logic       on_v_arm;

  always_comb begin
    dx       = (h_value >= vert_line) ? (h_value - vert_line) : (vert_line - h_value);
    dy       = (v_value >= horz_line) ? (v_value - horz_line) : (horz_line - v_value);
    on_h_arm = (v_value == horz_line) && (dx <= ARM);
    on_v_arm = (h_value == vert_line) && ({1'b0, dy} <= ARM);
  end

  always_ff @(posedge ball_clock or negedge reset_n) begin
    if (!reset_n) begin
      marker <= 1'b0;
    end else begin
      marker <= ball_found & h_sync & v_sync & (on_h_arm | on_v_arm);
    end
  end
`else
  // Elaborates to a constant 0; referencing MARKER_LEN keeps the parameter meaningful in both builds.
  assign marker = (MARKER_LEN < 0);
`endif

endmodule
